// File: rtl/ram_sp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_pkg
// Description : Shared types for the single-port RAM request front-end.
//               Controller state encoding and arbiter grant encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_sp_pkg;

  // Controller sequence: one idle cycle, RAM fill, then normal traffic.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } ctrl_state_t;

  // Encoding of the last-granted channel held by the round-robin arbiter.
  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

endpackage : ram_sp_pkg
`default_nettype wire

// File: rtl/ram_sp_rsp_buf.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_rsp_buf
// Description : Two-entry read-response FIFO. The head entry is always at
//               r_data0 so the output holds its last value while empty.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_push/i_push_data - write one entry
//               i_pop              - remove head entry (ignored when empty)
//               o_valid/o_data     - head entry and its valid flag
//               o_occupancy        - number of stored entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sp_rsp_buf #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_occupancy
);

  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic [1:0]            r_occ;
  logic                  w_pop;

  assign w_pop       = i_pop & (r_occ != 2'd0);
  assign o_valid     = (r_occ != 2'd0);
  assign o_data      = r_data0;
  assign o_occupancy = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_occ   <= 2'd0;
    end else begin
      if (w_pop) begin
        if (r_occ == 2'd2) begin
          // Second entry moves up; an arriving push refills the tail slot.
          r_data0 <= r_data1;
          if (i_push) begin
            r_data1 <= i_push_data;
          end
        end else if (i_push) begin
          // Single entry popped and replaced in the same cycle.
          r_data0 <= i_push_data;
        end
      end else if (i_push) begin
        if (r_occ == 2'd0) begin
          r_data0 <= i_push_data;
        end else begin
          r_data1 <= i_push_data;
        end
      end
      r_occ <= r_occ + 2'(i_push) - 2'(w_pop);
    end
  end

endmodule : ram_sp_rsp_buf
`default_nettype wire

// File: rtl/ram_sp_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_req_ctrl
// Description : Request front-end for a single-port synchronous RAM. Fills
//               the RAM with INIT_VALUE after reset, then arbitrates write
//               and read channels round-robin onto the RAM port and returns
//               read data through a 2-entry response buffer.
// Ports       : clk, rst_n                        - clock, async reset
//               init_done                         - fill sequence complete
//               wr_valid/wr_ready/wr_addr/wr_data - write requests
//               rd_valid/rd_ready/rd_addr         - read requests
//               rsp_valid/rsp_ready/rsp_data      - read responses
//               ram_we/ram_re/ram_addr/ram_wdata  - RAM port drive
//               ram_rdata                         - RAM data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sp_req_ctrl
  import ram_sp_pkg::*;
#(
  parameter int                    DATA_WIDTH = 4,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] c_init_last = ADDR_WIDTH'(RAM_DEPTH - 1);

  ctrl_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_last_grant;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [DATA_WIDTH-1:0] r_hold_wdata;

  logic                  w_run;
  logic [1:0]            w_occ;
  logic                  w_pop;
  logic                  w_rd_adm;
  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_gnt_wr;
  logic                  w_gnt_rd;

  assign w_run     = (r_state == RUN);
  assign init_done = w_run;
  assign w_pop     = rsp_valid & rsp_ready;

  // A read may issue only if, after this cycle's pop, the entries already
  // buffered plus the one still in the RAM pipeline leave room for it.
  assign w_rd_adm = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  assign w_wr_req = w_run & wr_valid;
  assign w_rd_req = w_run & rd_valid & w_rd_adm;

  // Round-robin: on contention the channel that did not win last time wins.
  assign w_gnt_wr = w_wr_req & (~w_rd_req | (r_last_grant == GRANT_RD));
  assign w_gnt_rd = w_rd_req & (~w_wr_req | (r_last_grant == GRANT_WR));

  assign wr_ready = w_gnt_wr;
  assign rd_ready = w_gnt_rd;

  // RAM port drive; address and data hold their previous value when idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = r_hold_addr;
    ram_wdata = r_hold_wdata;
    case (r_state)
      IDLE: begin
        ram_addr  = '0;
        ram_wdata = '0;
      end
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = r_init_cnt;
        ram_wdata = INIT_VALUE;
      end
      RUN: begin
        if (w_gnt_wr) begin
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end else if (w_gnt_rd) begin
          ram_re    = 1'b1;
          ram_addr  = rd_addr;
        end
      end
      default: begin
        ram_addr  = '0;
        ram_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_init_cnt   <= '0;
      r_last_grant <= GRANT_RD;
      r_inflight   <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
    end else begin
      r_hold_addr  <= ram_addr;
      r_hold_wdata <= ram_wdata;
      r_inflight   <= w_gnt_rd;
      case (r_state)
        IDLE: begin
          r_init_cnt <= '0;
          r_state    <= INIT;
        end
        INIT: begin
          if (r_init_cnt == c_init_last) begin
            r_state <= RUN;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        RUN: begin
          if (w_gnt_wr) begin
            r_last_grant <= GRANT_WR;
          end else if (w_gnt_rd) begin
            r_last_grant <= GRANT_RD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM read data is valid the cycle after ram_re, i.e. while r_inflight.
  ram_sp_rsp_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (ram_rdata),
    .i_pop       (rsp_ready),
    .o_valid     (rsp_valid),
    .o_data      (rsp_data),
    .o_occupancy (w_occ)
  );

endmodule : ram_sp_req_ctrl
`default_nettype wire

// File: tb/tb_ram_sp_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sp_req_ctrl
// Description : Self-checking bench for ram_sp_req_ctrl with a behavioural
//               RAM, a transaction-level reference model and directed plus
//               randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sp_req_ctrl;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic          wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0, rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  ram_sp_req_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (DEPTH),
    .INIT_VALUE ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Behavioural single-port synchronous RAM.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: memory contents, outstanding reads (data + issue cycle)
  // and the last granted channel. Sampled on the falling edge.
  // --------------------------------------------------------------------------
  int            cyc;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] q_data[$];
  int            q_cyc[$];
  bit            m_last_rd;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic [DW-1:0] h_rsp;
  bit            e_rv, e_pop, e_rok, e_gw, e_gr;
  int            e_outst;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc       = 0;
      q_data.delete();
      q_cyc.delete();
      m_last_rd = 1'b1;
      h_addr    = '0;
      h_wdata   = '0;
      h_rsp     = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      if (cyc <= DEPTH) begin
        check("init_done_low", init_done, 0);
        check("init_ready", {wr_ready, rd_ready}, 0);
        check("init_rsp_valid", rsp_valid, 0);
        check("init_re", ram_re, 0);
        check("init_we", ram_we, (cyc >= 1));
        check("init_addr", ram_addr, (cyc >= 1) ? 32'(cyc - 1) : 0);
        check("init_wdata", ram_wdata, 0);
        if (cyc >= 1) begin
          h_addr  = AW'(cyc - 1);
          h_wdata = '0;
        end
      end else begin
        e_rv = (q_cyc.size() > 0) && (q_cyc[0] <= cyc - 2);
        check("init_done", init_done, 1);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_data", rsp_data, e_rv ? q_data[0] : h_rsp);
        e_pop   = e_rv && rsp_ready;
        e_outst = q_data.size();
        e_rok   = rd_valid && ((e_outst - int'(e_pop)) < 2);
        e_gw    = wr_valid && (!e_rok || m_last_rd);
        e_gr    = e_rok && (!wr_valid || !m_last_rd);
        e_addr  = e_gw ? wr_addr : (e_gr ? rd_addr : h_addr);
        e_wdata = e_gw ? wr_data : h_wdata;
        check("wr_ready", wr_ready, e_gw);
        check("rd_ready", rd_ready, e_gr);
        check("ram_we", ram_we, e_gw);
        check("ram_re", ram_re, e_gr);
        check("ram_addr", ram_addr, e_addr);
        check("ram_wdata", ram_wdata, e_wdata);
        if (e_rv) h_rsp = q_data[0];
        if (e_pop) begin
          void'(q_data.pop_front());
          void'(q_cyc.pop_front());
        end
        if (e_gw) begin
          m_mem[wr_addr] = wr_data;
          m_last_rd = 1'b0;
        end
        if (e_gr) begin
          q_data.push_back(m_mem[rd_addr]);
          q_cyc.push_back(cyc);
          m_last_rd = 1'b1;
        end
        h_addr  = e_addr;
        h_wdata = e_wdata;
      end
      cyc++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    check("rst_init_done", init_done, 0);
    check("rst_ready", {wr_ready, rd_ready}, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ram_we_re", {ram_we, ram_re}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
  endtask

  // Leaves the caller 1 unit into cycle RAM_DEPTH+1 (first RUN cycle).
  task automatic do_reset(input bit hold_valids);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) tick();
    check_reset_outs();
    rst_n = 1'b1;
    if (hold_valids) begin
      wr_valid = 1'b1;
      rd_valid = 1'b1;
    end
    repeat (DEPTH) tick();
    check("init_done_pre", init_done, 0);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    tick();
    check("init_done_rise", init_done, 1);
  endtask

  task automatic wr_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    #1;
    while (!wr_ready && n < 50) begin tick(); #1; n++; end
    if (n >= 50) check("wr_timeout", 1, 0);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_req(input logic [AW-1:0] a);
    int n = 0;
    rd_valid = 1'b1; rd_addr = a;
    #1;
    while (!rd_ready && n < 50) begin tick(); #1; n++; end
    if (n >= 50) check("rd_timeout", 1, 0);
    tick();
    rd_valid = 1'b0;
  endtask

  logic [1:0]    g_seq [6];
  logic [DW-1:0] first_rsp;
  bit            seen;
  int            acc, nvalid, run_len, max_run;

  initial begin
    // Init sequence with both valids held, then every address reads 0.
    do_reset(1'b1);
    for (int a = 0; a < DEPTH; a++) rd_req(AW'(a));
    repeat (4) tick();

    // Write then read: response two cycles after the read handshake.
    wr_req(4'd3, 4'hA);
    rd_req(4'd3);
    tick();
    check("wtr_valid", rsp_valid, 1);
    check("wtr_data", rsp_data, 4'hA);
    repeat (3) tick();

    // Simultaneous requests immediately after init.
    do_reset(1'b0);
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 4'h7;
    rd_valid = 1'b1; rd_addr = 4'd5;
    seen = 1'b0; first_rsp = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      g_seq[i] = {wr_ready, rd_ready};
      if (rsp_valid && !seen) begin seen = 1'b1; first_rsp = rsp_data; end
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("sim_g0", g_seq[0], 2'b10);
    check("sim_g1", g_seq[1], 2'b01);
    check("sim_g2", g_seq[2], 2'b10);
    check("sim_g3", g_seq[3], 2'b01);
    check("sim_first_rsp", first_rsp, 4'h7);
    repeat (4) tick();

    // Distinct contents for the backpressure and streaming phases.
    for (int a = 0; a < 8; a++) wr_req(AW'(a), DW'(a + 1));

    // Backpressure: only two reads fit; a write still goes through.
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = (i == 3); wr_addr = 4'd9; wr_data = 4'h5;
      #1;
      if (rd_ready) begin acc++; end
      if (i == 3) check("bp_wr_ready", wr_ready, 1);
      tick();
      if (acc > 0) rd_addr = AW'(acc);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("bp_accepted", acc, 2);
    rsp_ready = 1'b1;
    repeat (6) tick();

    // Streaming: 8 back-to-back reads, 8 consecutive responses.
    nvalid = 0; run_len = 0; max_run = 0;
    rd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) rd_addr = AW'(i); else rd_valid = 1'b0;
      #1;
      if (i < 8) check("st_rd_ready", rd_ready, 1);
      if (rsp_valid) begin nvalid++; run_len++; end else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      tick();
    end
    rd_valid = 1'b0;
    check("st_count", nvalid, 8);
    check("st_run", max_run, 8);

    // Randomized mixed traffic with random response backpressure.
    for (int i = 0; i < 400; i++) begin
      wr_valid  = ($urandom_range(0, 99) < 50);
      rd_valid  = ($urandom_range(0, 99) < 60);
      wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      wr_data   = DW'($urandom);
      rd_addr   = AW'($urandom_range(0, DEPTH - 1));
      rsp_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) tick();

    // Reset mid-operation with two responses buffered.
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd2;
    repeat (4) tick();
    rd_valid = 1'b0;
    #1;
    check("mid_buffered", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check_reset_outs();
    do_reset(1'b1);

    for (int i = 0; i < 100; i++) begin
      wr_valid  = $urandom_range(0, 1) == 1;
      rd_valid  = $urandom_range(0, 1) == 1;
      wr_addr   = AW'($urandom);
      wr_data   = DW'($urandom);
      rd_addr   = AW'($urandom);
      rsp_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_sp_req_ctrl
`default_nettype wire
